// File: rtl/playlist_controller.sv
// Playlist sequencer for the song reader: 4-entry song-ID queue, play/pause/skip
// control, auto-advance on song_done and optional re-queue of finished songs.
module playlist_controller #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned SONG_W = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     play_button,
    input  logic                     next_button,
    input  logic                     enqueue,
    input  logic [SONG_W-1:0]        enq_song,
    input  logic                     repeat_mode,
    input  logic                     song_done,
    output logic                     play,
    output logic [SONG_W-1:0]        song,
    output logic                     reset_player,
    output logic [$clog2(DEPTH):0]   queue_count,
    output logic                     queue_empty,
    output logic                     queue_full,
    output logic                     enq_reject
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PLAYING,
        PAUSED,
        ADVANCE
    } state_t;

    state_t             state, state_n;
    logic               from_pause, from_pause_n;
    logic [SONG_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]   head, tail;
    logic [CNT_W-1:0]   count, count_n;
    logic [SONG_W-1:0]  song_n;
    logic               pop, rpt_push, enq_ok, push;
    logic [SONG_W-1:0]  push_data;
    logic               has_entry;

    assign has_entry = (count != '0);

    always_comb begin
        state_n      = state;
        from_pause_n = from_pause;
        pop          = 1'b0;
        rpt_push     = 1'b0;
        case (state)
            IDLE: begin
                if (play_button && has_entry) begin
                    pop          = 1'b1;
                    from_pause_n = 1'b0;
                    state_n      = LOAD;
                end
            end
            LOAD: state_n = from_pause ? PAUSED : PLAYING;
            PLAYING: begin
                if (song_done || next_button) begin
                    from_pause_n = 1'b0;
                    state_n      = ADVANCE;
                end else if (play_button) begin
                    state_n = PAUSED;
                end
            end
            PAUSED: begin
                if (next_button) begin
                    from_pause_n = 1'b1;
                    state_n      = ADVANCE;
                end else if (play_button) begin
                    state_n = PLAYING;
                end
            end
            ADVANCE: begin
                // Repeat on an empty queue would push and pop the same entry,
                // so the current song is simply kept without touching the FIFO.
                if (repeat_mode) begin
                    rpt_push = has_entry;
                    pop      = has_entry;
                    state_n  = LOAD;
                end else if (has_entry) begin
                    pop     = 1'b1;
                    state_n = LOAD;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        enq_ok    = enqueue && !(state == ADVANCE && repeat_mode)
                    && ((count < CNT_W'(DEPTH)) || pop);
        push      = enq_ok || rpt_push;
        push_data = rpt_push ? song : enq_song;
        song_n    = pop ? mem[head] : song;
        count_n   = count;
        if (push && !pop)
            count_n = count + CNT_W'(1);
        else if (pop && !push)
            count_n = count - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            from_pause   <= 1'b0;
            play         <= 1'b0;
            song         <= '0;
            reset_player <= 1'b0;
            enq_reject   <= 1'b0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            queue_count  <= '0;
            queue_empty  <= 1'b1;
            queue_full   <= 1'b0;
        end else begin
            state        <= state_n;
            from_pause   <= from_pause_n;
            play         <= (state_n == PLAYING);
            reset_player <= (state_n == LOAD);
            song         <= song_n;
            enq_reject   <= enqueue && !enq_ok;
            if (pop)
                head <= head + PTR_W'(1);
            if (push)
                tail <= tail + PTR_W'(1);
            count        <= count_n;
            queue_count  <= count_n;
            queue_empty  <= (count_n == '0);
            queue_full   <= (count_n == CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[tail] <= push_data;
    end

endmodule

// File: tb/tb_playlist_controller.sv
// Directed vector bench for playlist_controller: table of per-cycle stimulus
// with expected registered outputs, plus hand sequences for repeat and reset.
module tb_playlist_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       play_button, next_button, enqueue, repeat_mode, song_done;
    logic [1:0] enq_song;
    logic       play, reset_player, queue_empty, queue_full, enq_reject;
    logic [1:0] song;
    logic [2:0] queue_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       pb, nb, enq, rep, sd;
        logic [1:0] es;
        logic       e_play, e_rp, e_empty, e_full, e_rej;
        logic [1:0] e_song;
        logic [2:0] e_cnt;
    } vec_t;

    vec_t tbl[29];

    playlist_controller #(.DEPTH(4), .SONG_W(2)) dut (
        .clk(clk), .reset(reset),
        .play_button(play_button), .next_button(next_button),
        .enqueue(enqueue), .enq_song(enq_song),
        .repeat_mode(repeat_mode), .song_done(song_done),
        .play(play), .song(song), .reset_player(reset_player),
        .queue_count(queue_count), .queue_empty(queue_empty),
        .queue_full(queue_full), .enq_reject(enq_reject)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int pb, nb, enq, es, rep, sd,
                                input int p, s, rp, c, rj);
        vec_t r;
        r.pb = 1'(pb); r.nb = 1'(nb); r.enq = 1'(enq); r.es = 2'(es);
        r.rep = 1'(rep); r.sd = 1'(sd);
        r.e_play = 1'(p); r.e_song = 2'(s); r.e_rp = 1'(rp);
        r.e_cnt = 3'(c); r.e_empty = (c == 0); r.e_full = (c == 4);
        r.e_rej = 1'(rj);
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input vec_t v);
        chk({tag, ".play"},         int'(play),         int'(v.e_play));
        chk({tag, ".song"},         int'(song),         int'(v.e_song));
        chk({tag, ".reset_player"}, int'(reset_player), int'(v.e_rp));
        chk({tag, ".queue_count"},  int'(queue_count),  int'(v.e_cnt));
        chk({tag, ".queue_empty"},  int'(queue_empty),  int'(v.e_empty));
        chk({tag, ".queue_full"},   int'(queue_full),   int'(v.e_full));
        chk({tag, ".enq_reject"},   int'(enq_reject),   int'(v.e_rej));
    endtask

    task automatic apply(input string tag, input vec_t v);
        play_button = v.pb; next_button = v.nb; enqueue = v.enq;
        enq_song = v.es; repeat_mode = v.rep; song_done = v.sd;
        @(posedge clk);
        #1;
        check_outs(tag, v);
    endtask

    initial begin
        reset = 1'b0;
        play_button = 1'b0; next_button = 1'b0; enqueue = 1'b0;
        enq_song = '0; repeat_mode = 1'b0; song_done = 1'b0;

        //          pb nb en es rp sd | play song rp cnt rej
        tbl[0]  = mk(0, 0, 1, 2, 0, 0,  0, 0, 0, 1, 0);
        tbl[1]  = mk(0, 0, 1, 1, 0, 0,  0, 0, 0, 2, 0);
        tbl[2]  = mk(1, 0, 0, 0, 0, 0,  0, 2, 1, 1, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0,  1, 2, 0, 1, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 1,  0, 2, 0, 1, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0);
        tbl[9]  = mk(1, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0);
        tbl[10] = mk(0, 0, 1, 0, 0, 0,  0, 1, 0, 1, 0);
        tbl[11] = mk(0, 0, 1, 1, 0, 0,  0, 1, 0, 2, 0);
        tbl[12] = mk(0, 0, 1, 2, 0, 0,  0, 1, 0, 3, 0);
        tbl[13] = mk(0, 0, 1, 3, 0, 0,  0, 1, 0, 4, 0);
        tbl[14] = mk(0, 0, 1, 0, 0, 0,  0, 1, 0, 4, 1);
        tbl[15] = mk(0, 0, 0, 0, 0, 0,  0, 1, 0, 4, 0);
        tbl[16] = mk(1, 0, 1, 3, 0, 0,  0, 0, 1, 4, 0);
        tbl[17] = mk(0, 0, 0, 0, 0, 0,  1, 0, 0, 4, 0);
        tbl[18] = mk(0, 0, 0, 0, 1, 1,  0, 0, 0, 4, 0);
        tbl[19] = mk(0, 0, 1, 2, 1, 0,  0, 1, 1, 4, 1);
        tbl[20] = mk(0, 0, 0, 0, 0, 0,  1, 1, 0, 4, 0);
        tbl[21] = mk(1, 0, 0, 0, 0, 0,  0, 1, 0, 4, 0);
        tbl[22] = mk(1, 0, 0, 0, 0, 0,  1, 1, 0, 4, 0);
        tbl[23] = mk(1, 0, 0, 0, 0, 0,  0, 1, 0, 4, 0);
        tbl[24] = mk(0, 0, 0, 0, 0, 1,  0, 1, 0, 4, 0);
        tbl[25] = mk(0, 1, 0, 0, 0, 0,  0, 1, 0, 4, 0);
        tbl[26] = mk(0, 1, 0, 0, 0, 0,  0, 2, 1, 3, 0);
        tbl[27] = mk(1, 0, 0, 0, 0, 0,  0, 2, 0, 3, 0);
        tbl[28] = mk(1, 0, 0, 0, 0, 0,  1, 2, 0, 3, 0);

        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b1;

        for (int i = 0; i < 29; i++)
            apply($sformatf("vec%0d", i), tbl[i]);

        // Single-song repeat loop, then asynchronous reset mid-song.
        reset = 1'b0;
        #2;
        reset = 1'b1;
        apply("rpt_enq",  mk(0, 0, 1, 3, 0, 0,  0, 0, 0, 1, 0));
        apply("rpt_pb",   mk(1, 0, 0, 0, 0, 0,  0, 3, 1, 0, 0));
        apply("rpt_play", mk(0, 0, 0, 0, 0, 0,  1, 3, 0, 0, 0));
        apply("rpt_done", mk(0, 0, 0, 0, 1, 1,  0, 3, 0, 0, 0));
        apply("rpt_load", mk(0, 0, 0, 0, 1, 0,  0, 3, 1, 0, 0));
        apply("rpt_back", mk(0, 0, 0, 0, 1, 0,  1, 3, 0, 0, 0));
        apply("mid_enq0", mk(0, 0, 1, 0, 0, 0,  1, 3, 0, 1, 0));
        apply("mid_enq1", mk(0, 0, 1, 1, 0, 0,  1, 3, 0, 2, 0));
        apply("mid_enq2", mk(0, 0, 0, 0, 0, 0,  1, 3, 0, 2, 0));
        apply("mid_enq3", mk(0, 0, 1, 2, 0, 0,  1, 3, 0, 3, 0));

        reset = 1'b0;
        #2;
        check_outs("async_rst", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b1;
        apply("post_pb",   mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
        apply("post_idle", mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/playlist_controller.md
# playlist_controller

Sequences the song reader by holding a 4-entry queue of requested song IDs and driving its `play`/`song` inputs. It owns play/pause and skip, advances automatically on `song_done`, and optionally re-queues finished songs. It sits between the button/UI debouncers and the song reader. It also pulses `reset_player` so the song reader and note player restart cleanly on every song change.

## Interface
- DEPTH, 4, queue entries (power of two; count width is log2(DEPTH)+1)
- SONG_W, 2, song ID width

- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- play_button  in  1  one-cycle pulse, toggles play/pause or starts from idle
- next_button  in  1  one-cycle pulse, skip to next queued song
- enqueue  in  1  one-cycle pulse, push `enq_song`
- enq_song  in  SONG_W  song ID to push
- repeat_mode  in  1  level; finished/skipped song is re-queued at tail
- song_done  in  1  from song reader, current song finished
- play  out  1  to song reader, registered
- song  out  SONG_W  to song reader, registered
- reset_player  out  1  one-cycle pulse on every song load
- queue_count  out  3  entries held, 0..4
- queue_empty  out  1  queue_count==0
- queue_full  out  1  queue_count==DEPTH
- enq_reject  out  1  one-cycle pulse, enqueue dropped

## Operation
- Queue: circular FIFO, head/tail pointers wrap modulo DEPTH, separate count register; one push and one pop per cycle permitted.
- States: IDLE, LOAD, PLAYING, PAUSED, ADVANCE.
- IDLE: play=0. `play_button` with queue non-empty pops head into `song` and goes to LOAD. `play_button` with empty queue is ignored.
- LOAD: `reset_player`=1 for exactly this cycle, play=0. Goes to PLAYING, or to PAUSED if entered from an ADVANCE started in PAUSED.
- PLAYING: play=1. Priority: `song_done` > `next_button` > `play_button`. `song_done` or `next_button` goes to ADVANCE. `play_button` goes to PAUSED.
- PAUSED: play=0, `song` held. `next_button` goes to ADVANCE with the paused flag set. `play_button` goes to PLAYING. `song_done` is ignored.
- ADVANCE (one cycle, play=0):
  - If `repeat_mode`, push current `song` at tail.
  - If the queue held ≥1 entry at cycle start, or a repeat push occurred, pop head into `song` and go to LOAD. With an empty queue and repeat set, the bypass returns the same song (single-song loop).
  - Otherwise go to IDLE; `song` holds its last value.
- Repeat push into a full queue occurs together with the pop, so it always succeeds.
- External enqueue:
  - Accepted when count<DEPTH, or when count==DEPTH and a pop occurs the same cycle.
  - Rejected in the ADVANCE cycle if `repeat_mode`=1 (write port in use).
  - A rejected push pulses `enq_reject` the next cycle; count is unchanged.
- Count update: +1 on push, -1 on pop, unchanged on both or neither.
- Reset (asynchronous, any state): state=IDLE, play=0, song=0, reset_player=0, enq_reject=0, pointers=0, count=0. Mid-song reset discards the queue.

## Timing
- All outputs are registered; all inputs are sampled on the rising edge of `clk`.
- Start: `play_button` sampled in IDLE at edge N. At N+1: `song`=head, reset_player=1. At N+2: play=1.
- Advance: `song_done` sampled at N. At N+1: ADVANCE, play=0. At N+2: new song, reset_player=1. At N+3: play=1. If the queue is empty without repeat, N+2 is IDLE.
- Pause/resume: `play` changes one cycle after the sampled button.
- `queue_count`, `queue_full` and `queue_empty` update on the edge after the push or pop.
- Buttons arriving in LOAD or ADVANCE are ignored.

## Test plan
- Reset, enqueue 2 then 1, then `play_button` → at N+1 song=2 and reset_player=1; at N+2 play=1; queue_count=1.
- PLAYING song 2 with song 1 queued; pulse `song_done` → play=0 for 2 cycles, song=1, then play=1. A second `song_done` → IDLE, play=0, queue_empty=1.
- Enqueue 5 songs back-to-back into an empty queue while IDLE → queue_full=1 after the 4th; 5th pulses enq_reject; queue_count=4.
- `repeat_mode`=1, single song 3 playing, queue empty, `song_done` → song=3 reloaded, reset_player pulses, queue_count=0.
- PAUSED on song 0, song 2 queued; `next_button` → song=2, reset_player pulses, play stays 0; `play_button` → play=1.
- Assert reset low mid-PLAYING with 3 queued → immediately play=0, song=0, queue_count=0; after release, `play_button` is ignored.
